// File: rtl/if_queue.sv
// Instruction queue between fetch and decode: a small circular FIFO holding
// {instr, pc} pairs with first-word fall-through to decode, a full flag that
// stalls fetch, and a single-cycle flush that empties the queue on a taken branch.
module if_queue #(
    parameter int PC_BITS    = 16,
    parameter int INSTR_BITS = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [INSTR_BITS-1:0]      instr_i,
    input  logic [PC_BITS-1:0]         pc_i,
    input  logic                       flush_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [INSTR_BITS-1:0]      instr_o,
    output logic [PC_BITS-1:0]         pc_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [INSTR_BITS-1:0] instr_q [DEPTH];
    logic [PC_BITS-1:0]    pc_q    [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic push_ok;
    logic pop_ok;

    // Acceptance is decided purely from registered occupancy, so no input
    // reaches an output combinationally. A full queue drops pushes and an
    // empty queue ignores pops; flush gates both off.
    always_comb begin
        push_ok = push_i && (count != FULL_CNT) && !flush_i;
        pop_ok  = pop_i  && (count != '0)       && !flush_i;
    end

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            instr_q[wr_ptr] <= instr_i;
            pc_q[wr_ptr]    <= pc_i;
        end
    end

    // Pointers wrap by natural overflow; flush collapses the queue to empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    // Head entry is shown straight from storage, zeroed while empty.
    always_comb begin
        valid_o = (count != '0);
        full_o  = (count == FULL_CNT);
        count_o = count;
        instr_o = valid_o ? instr_q[rd_ptr] : '0;
        pc_o    = valid_o ? pc_q[rd_ptr]    : '0;
    end

endmodule

// File: tb/tb_if_queue.sv
// Bench for if_queue: a queue-based reference model checked every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_if_queue;

    localparam int PC_BITS    = 16;
    localparam int INSTR_BITS = 16;
    localparam int DEPTH      = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  push_i = 1'b0;
    logic [INSTR_BITS-1:0] instr_i = '0;
    logic [PC_BITS-1:0]    pc_i = '0;
    logic                  flush_i = 1'b0;
    logic                  pop_i = 1'b0;
    logic                  valid_o;
    logic [INSTR_BITS-1:0] instr_o;
    logic [PC_BITS-1:0]    pc_o;
    logic                  full_o;
    logic [CW-1:0]         count_o;

    int nvec = 0;
    int nerr = 0;

    if_queue #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .instr_i(instr_i),
        .pc_i(pc_i), .flush_i(flush_i), .pop_i(pop_i), .valid_o(valid_o),
        .instr_o(instr_o), .pc_o(pc_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] instr;
    } ent_t;

    ent_t                 mq[$];
    logic [PC_BITS-1:0]   out_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries, updated from the sampled inputs.
    always @(posedge clk_i or posedge rst_i) begin
        int n;
        n = mq.size();
        if (rst_i || flush_i) begin
            mq.delete();
        end else begin
            if (pop_i && n > 0) begin
                out_log.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (push_i && n < DEPTH) mq.push_back('{pc_i, instr_i});
        end
    end

    // Every cycle, on the falling edge, the DUT outputs must match the model.
    always @(negedge clk_i) begin
        int n;
        n = mq.size();
        chk("valid", 32'(valid_o), 32'(n > 0));
        chk("full",  32'(full_o),  32'(n == DEPTH));
        chk("count", 32'(count_o), 32'(n));
        chk("instr", 32'(instr_o), (n > 0) ? 32'(mq[0].instr) : 32'd0);
        chk("pc",    32'(pc_o),    (n > 0) ? 32'(mq[0].pc)    : 32'd0);
    end

    // One clock of stimulus; returns 1 time unit after the edge it drove.
    task automatic cyc(input logic p, input logic [15:0] pc, input logic [15:0] ins,
                       input logic po, input logic fl, input logic r);
        @(negedge clk_i);
        #1;
        rst_i   = r;
        push_i  = p;
        pc_i    = pc;
        instr_i = ins;
        pop_i   = po;
        flush_i = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic push(input logic [15:0] pc, input logic [15:0] ins); cyc(1, pc, ins, 0, 0, 0); endtask
    task automatic pop(); cyc(0, 0, 0, 1, 0, 0); endtask

    task automatic chk_log(input string name, input logic [15:0] exp[$]);
        chk({name, "_len"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(name, 32'(out_log[i]), 32'(exp[i]));
        out_log.delete();
    endtask

    initial begin
        logic [15:0] exp[$];

        // Reset state before any clock edge
        #2;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_full",  32'(full_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_instr", 32'(instr_o), 0);
        chk("rst_pc",    32'(pc_o), 0);
        idle();
        idle();

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) push(16'(4 * i), 16'(16'hA0 + i));
        chk("fill_full",  32'(full_o), 1);
        chk("fill_count", 32'(count_o), 4);
        chk("fill_head_instr", 32'(instr_o), 32'hA0);
        push(16'h10, 16'hA4);
        chk("ovf_count", 32'(count_o), 4);
        out_log.delete();
        for (int i = 0; i < 4; i++) pop();
        exp = '{16'h0, 16'h4, 16'h8, 16'hC};
        chk_log("drain_order", exp);
        chk("drain_valid", 32'(valid_o), 0);
        pop();
        chk("extra_pop_count", 32'(count_o), 0);
        out_log.delete();

        // Wrap-around
        push(16'h0, 16'hB0); push(16'h4, 16'hB1); push(16'h8, 16'hB2);
        pop(); pop();
        out_log.delete();
        push(16'h20, 16'hB3); push(16'h24, 16'hB4); push(16'h28, 16'hB5);
        chk("wrap_count", 32'(count_o), 4);
        for (int i = 0; i < 4; i++) pop();
        exp = '{16'h8, 16'h20, 16'h24, 16'h28};
        chk_log("wrap_order", exp);

        // Simultaneous push and pop, empty then full
        cyc(1, 16'h30, 16'hC0, 1, 0, 0);
        chk("sim_empty_count", 32'(count_o), 1);
        chk("sim_empty_pc",    32'(pc_o), 32'h30);
        push(16'h34, 16'hC1); push(16'h38, 16'hC2); push(16'h3C, 16'hC3);
        chk("sim_full_pre", 32'(full_o), 1);
        cyc(1, 16'h50, 16'hC4, 1, 0, 0);
        chk("sim_full_count", 32'(count_o), 3);
        out_log.delete();
        for (int i = 0; i < 3; i++) pop();
        exp = '{16'h34, 16'h38, 16'h3C};
        chk_log("sim_full_order", exp);

        // Flush together with push and pop
        push(16'h60, 16'hD0); push(16'h64, 16'hD1); push(16'h68, 16'hD2);
        cyc(1, 16'h40, 16'hD3, 1, 1, 0);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_valid", 32'(valid_o), 0);
        push(16'h44, 16'hD4);
        chk("post_flush_pc",    32'(pc_o), 32'h44);
        chk("post_flush_count", 32'(count_o), 1);
        out_log.delete();

        // Streaming at occupancy 1
        exp = '{16'h44};
        for (int i = 0; i < 20; i++) begin
            cyc(1, 16'(16'h100 + 4 * i), 16'(i), 1, 0, 0);
            chk("stream_count", 32'(count_o), 1);
            if (i < 19) exp.push_back(16'(16'h100 + 4 * i));
        end
        chk_log("stream_order", exp);

        // Asynchronous reset mid-operation
        push(16'h70, 16'hE0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_o), 0);
        chk("async_rst_count", 32'(count_o), 0);
        chk("async_rst_pc",    32'(pc_o), 0);
        chk("async_rst_instr", 32'(instr_o), 0);
        chk("async_rst_full",  32'(full_o), 0);
        idle();
        out_log.delete();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0,
                $urandom_range(0, 299) == 0);
            out_log.delete();
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction queue between the fetch stage and decode. It captures each fetched instruction with its PC into a small circular FIFO. It presents the oldest entry to decode through a valid/pop handshake and raises `full_o` as the fetch stall. On a taken branch it discards every queued entry in one cycle, so no wrong-path instruction reaches decode.

## Interface
- `PC_BITS`, 16, width of the PC field.
- `INSTR_BITS`, 16, width of the instruction field.
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.

- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `push_i`  in  1  fetch presents a valid instruction this cycle.
- `instr_i`  in  INSTR_BITS  instruction from fetch.
- `pc_i`  in  PC_BITS  PC of `instr_i`.
- `flush_i`  in  1  taken branch; discard all entries.
- `pop_i`  in  1  decode consumes the head entry this cycle.
- `valid_o`  out  1  head entry is valid.
- `instr_o`  out  INSTR_BITS  head instruction; all zeros when `valid_o`=0.
- `pc_o`  out  PC_BITS  head PC; all zeros when `valid_o`=0.
- `full_o`  out  1  `count_o`==DEPTH; fetch stall.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **State:**
  - Storage arrays `instr_q[DEPTH]` and `pc_q[DEPTH]`.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits.
  - Occupancy register `count`.
  - Pointers wrap modulo DEPTH through natural overflow.
- **Reset:** `wr_ptr`, `rd_ptr` and `count` go to 0. Storage is not reset. `valid_o`, `full_o`, `count_o`, `instr_o` and `pc_o` all read 0.
- **Output decode:**
  - `valid_o` = (count != 0).
  - `full_o` = (count == DEPTH).
  - `instr_o` and `pc_o` = head entry (`instr_q[rd_ptr]`, `pc_q[rd_ptr]`) when valid, otherwise 0. This is first-word fall-through: the head is visible combinationally from storage.
- **Push acceptance:** a push is accepted when `push_i` && !`full_o`. It writes entry `wr_ptr` and increments `wr_ptr`.
  - A push while full is dropped with no state change. Fetch is required to hold on `full_o`.
- **Pop acceptance:** a pop is accepted when `pop_i` && `valid_o`. It increments `rd_ptr`.
  - A pop while empty is ignored.
- **Count update:** +1 for an accepted push only, -1 for an accepted pop only, unchanged when both are accepted.
- **Simultaneous push and pop:**
  - Empty: the push is accepted, the pop is ignored, and `count` becomes 1.
  - Full: the pop is accepted, the push is rejected (`full_o` is already 1), and `count` becomes DEPTH-1.
  - 0<count<DEPTH: both are accepted and `count` is unchanged.
- **Flush priority:** `flush_i` has priority over everything. `wr_ptr`, `rd_ptr` and `count` go to 0. A same-cycle push is discarded and a same-cycle pop has no effect.
- **Reset mid-operation:** asserting `rst_i` at any time clears the queue immediately; outputs read 0 without waiting for a clock edge.

## Timing
- **Push latency:** an entry pushed at edge N is visible on `valid_o`, `instr_o` and `pc_o` after edge N (the same cycle as `count` updates). A queue that is empty before the edge therefore shows the entry one cycle after `push_i`.
- **Pop timing:** `pop_i` acts at the edge. The next entry, or `valid_o`=0, is shown in the following cycle.
- **Full/stall timing:** `full_o` rises in the cycle after the DEPTH-th accepted push. It falls in the cycle after the first pop from full.
- **Flush timing:** after the flush edge, `valid_o`=0, `full_o`=0 and `count_o`=0. A push in the cycle after the flush is accepted normally.
- **Throughput:** sustained one push and one pop per cycle in steady state with 0<count<DEPTH.
- No combinational path from `push_i`, `pop_i` or `flush_i` to any output.

## Test plan
- **Reset:** assert `rst_i` asynchronously between clock edges. Required: `valid_o`=0, `full_o`=0, `count_o`=0, `instr_o`=0 and `pc_o`=0 before the next edge.
- **Fill, overflow and drain (DEPTH=4):**
  - Push PCs 0x0,0x4,0x8,0xC with instrs 0xA0..0xA3. Required: `full_o`=1 and `count_o`=4.
  - A 5th push (PC 0x10) is dropped.
  - Pop ×4. Required: `pc_o` reads 0x0,0x4,0x8,0xC in order, then `valid_o`=0.
  - A 5th pop leaves `count_o`=0.
- **Wrap-around:**
  - Push 3, pop 2, push 3 (PCs 0x20,0x24,0x28). Required: `count_o`=4.
  - Drain. Required: order 0x8,0x20,0x24,0x28, confirming pointer wrap.
- **Simultaneous push and pop:**
  - Empty + push + pop. Required: `count_o`=1 and head = pushed PC.
  - Full + push + pop. Required: `count_o`=3 and the pushed entry is absent when drained.
- **Flush with push and pop:** with 3 entries, assert `flush_i`, `push_i` (PC 0x40) and `pop_i` together. Required: `count_o`=0 and `valid_o`=0. A push of PC 0x44 next cycle then appears as head.
- **Streaming:** 20 consecutive cycles of push+pop with `count_o`=1. Required: `count_o` stays 1 and the PC sequence out equals the PC sequence in, delayed by one entry.
